// File: rtl/uart_tx_pkg.sv
// Shared UART transmitter types: FSM state encoding and the idle level of the serial line.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    s_IDLE         = 3'd0,
    s_TX_START_BIT = 3'd1,
    s_TX_DATA_BITS = 3'd2,
    s_TX_STOP_BIT  = 3'd3,
    s_CLEANUP      = 3'd4
  } state_t;

  localparam logic SERIAL_IDLE = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// Host-side byte handshake and serial/status outputs of the UART transmitter.
interface uart_tx_if;

  logic       i_TX_DV;
  logic [7:0] i_TX_Byte;
  logic       o_TX_Serial;
  logic       o_TX_Active;
  logic       o_TX_Done;

  modport master (
    output i_TX_DV, i_TX_Byte,
    input  o_TX_Serial, o_TX_Active, o_TX_Done
  );

  modport slave (
    input  i_TX_DV, i_TX_Byte,
    output o_TX_Serial, o_TX_Active, o_TX_Done
  );

endinterface

// File: rtl/uart_tx_clk_counter.sv
// Bit-period timer: strobes clk_count_enable on the last cycle of each start/data/stop
// bit and immediately in cleanup; tracks the controller state by registering next_state.
module uart_tx_clk_counter
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic   clk,
  input  logic   rst,
  input  state_t next_state,
  output logic   clk_count_enable
);

  localparam int                CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= s_IDLE;
      count <= '0;
    end else begin
      state <= next_state;
      if (clk_count_enable || (state == s_IDLE)) begin
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

  always_comb begin
    clk_count_enable = 1'b0;
    case (state)
      s_TX_START_BIT,
      s_TX_DATA_BITS,
      s_TX_STOP_BIT:  clk_count_enable = (count == CNT_LAST);
      s_CLEANUP:      clk_count_enable = 1'b1;
      default:        clk_count_enable = 1'b0;
    endcase
  end

endmodule

// File: rtl/uart_tx_shift_reg.sv
// Frame data holding register with bit index counter; bit_out presents the bit selected
// by the index the counter will hold after the coming edge.
module uart_tx_shift_reg #(
  parameter int DATA_BITS = 8,
  parameter int IDX_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 clear,
  input  logic                 advance,
  input  logic [DATA_BITS-1:0] data,
  output logic [IDX_W-1:0]     index,
  output logic                 bit_out
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic [DATA_BITS-1:0] sreg;
  logic [IDX_W-1:0]     index_next;

  // Index saturates at the last data bit so it can never wrap.
  always_comb begin
    index_next = index;
    if (load || clear) begin
      index_next = '0;
    end else if (advance && (index != LAST_IDX)) begin
      index_next = index + IDX_W'(1);
    end
  end

  assign bit_out = sreg[index_next];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg  <= '0;
      index <= '0;
    end else begin
      if (load) begin
        sreg <= data;
      end
      index <= index_next;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART 8N1 transmit control FSM: accepts a host byte, sequences start/data/stop bits
// against the bit-period strobe and drives the registered serial line and status flags.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic     i_Clock,
  input  logic     i_Reset,
  uart_tx_if.slave host,
  input  logic     clk_count_enable,
  output state_t   next_state
);

  localparam int               IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  state_t           state;
  logic             load;
  logic             clear;
  logic             advance;
  logic             bit_out;
  logic             serial_next;
  logic [IDX_W-1:0] index;
  logic             unused_byte_bits;

  assign unused_byte_bits = ^host.i_TX_Byte;

  uart_tx_shift_reg #(
    .DATA_BITS (DATA_BITS),
    .IDX_W     (IDX_W)
  ) u_shift (
    .clk     (i_Clock),
    .rst     (i_Reset),
    .load    (load),
    .clear   (clear),
    .advance (advance),
    .data    (host.i_TX_Byte[DATA_BITS-1:0]),
    .index   (index),
    .bit_out (bit_out)
  );

  always_comb begin
    next_state = state;
    load       = 1'b0;
    clear      = 1'b0;
    advance    = 1'b0;
    case (state)
      s_IDLE: begin
        if (host.i_TX_DV) begin
          next_state = s_TX_START_BIT;
          load       = 1'b1;
        end
      end
      s_TX_START_BIT: begin
        if (clk_count_enable) begin
          next_state = s_TX_DATA_BITS;
          clear      = 1'b1;
        end
      end
      s_TX_DATA_BITS: begin
        if (clk_count_enable) begin
          if (index == LAST_IDX) begin
            next_state = s_TX_STOP_BIT;
          end else begin
            advance = 1'b1;
          end
        end
      end
      s_TX_STOP_BIT: begin
        if (clk_count_enable) next_state = s_TX_STOP_BIT == state ? s_CLEANUP : s_IDLE;
      end
      s_CLEANUP: begin
        if (clk_count_enable) next_state = s_IDLE;
      end
      default: next_state = s_IDLE;
    endcase
    // Reset overrides everything so the counter sees IDLE in the same cycle.
    if (i_Reset) begin
      next_state = s_IDLE;
      load       = 1'b0;
      clear      = 1'b0;
      advance    = 1'b0;
    end
  end

  // Line level is decoded from next_state so it moves on the same edge as the state.
  always_comb begin
    serial_next = SERIAL_IDLE;
    case (next_state)
      s_TX_START_BIT: serial_next = 1'b0;
      s_TX_DATA_BITS: serial_next = bit_out;
      default:        serial_next = SERIAL_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state            <= s_IDLE;
      host.o_TX_Serial <= SERIAL_IDLE;
      host.o_TX_Active <= 1'b0;
      host.o_TX_Done   <= 1'b0;
    end else begin
      state            <= next_state;
      host.o_TX_Serial <= serial_next;
      host.o_TX_Active <= (next_state != s_IDLE);
      host.o_TX_Done   <= (next_state == s_CLEANUP);
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl paired with uart_tx_clk_counter (4 clocks per bit),
// with one 8-bit and one 5-bit instance.
module tb_uart_tx_ctrl;
  import uart_tx_pkg::*;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_if bus8 ();
  uart_tx_if bus5 ();

  state_t ns8, ns5;
  logic   en8, en5;

  uart_tx_ctrl #(.DATA_BITS(8)) dut8 (
    .i_Clock(clk), .i_Reset(rst), .host(bus8), .clk_count_enable(en8), .next_state(ns8)
  );
  uart_tx_clk_counter #(.CLKS_PER_BIT(CPB)) cnt8 (
    .clk(clk), .rst(rst), .next_state(ns8), .clk_count_enable(en8)
  );
  uart_tx_ctrl #(.DATA_BITS(5)) dut5 (
    .i_Clock(clk), .i_Reset(rst), .host(bus5), .clk_count_enable(en5), .next_state(ns5)
  );
  uart_tx_clk_counter #(.CLKS_PER_BIT(CPB)) cnt5 (
    .clk(clk), .rst(rst), .next_state(ns5), .clk_count_enable(en5)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected line, cycle k = k-th sample after the accept edge.
  function automatic logic [63:0] exp_line(input logic [7:0] b, input int nb);
    logic [63:0] v;
    v = '1;
    for (int k = 0; k < CPB; k++) v[k] = 1'b0;
    for (int i = 0; i < nb; i++)
      for (int j = 0; j < CPB; j++) v[CPB*(i+1)+j] = b[i];
    return v;
  endfunction

  function automatic logic [63:0] exp_act(input int nb);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k <= CPB*(nb+2); k++) v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] exp_done(input int nb);
    logic [63:0] v;
    v = '0;
    v[CPB*(nb+2)] = 1'b1;
    return v;
  endfunction

  task automatic record(input bit sel5, input int n,
                        output logic [63:0] ln, output logic [63:0] ac, output logic [63:0] dn);
    ln = '0; ac = '0; dn = '0;
    for (int i = 0; i < n; i++) begin
      ln[i] = sel5 ? bus5.o_TX_Serial : bus8.o_TX_Serial;
      ac[i] = sel5 ? bus5.o_TX_Active : bus8.o_TX_Active;
      dn[i] = sel5 ? bus5.o_TX_Done   : bus8.o_TX_Done;
      @(posedge clk); #1;
    end
  endtask

  task automatic send(input bit sel5, input logic [7:0] b);
    if (sel5) begin bus5.i_TX_DV = 1'b1; bus5.i_TX_Byte = b; end
    else      begin bus8.i_TX_DV = 1'b1; bus8.i_TX_Byte = b; end
    @(posedge clk); #1;
    if (sel5) bus5.i_TX_DV = 1'b0;
    else      bus8.i_TX_DV = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    n_checks++;
    if (bus8.o_TX_Serial !== 1'b1 || bus8.o_TX_Active !== 1'b0 || bus8.o_TX_Done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ser=%b act=%b done=%b, want 1 0 0",
               bus8.o_TX_Serial, bus8.o_TX_Active, bus8.o_TX_Done);
    end
    n_checks++;
    if (ns8 !== s_IDLE || bus5.o_TX_Serial !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got ns=%0d ser5=%b, want 0 1", ns8, bus5.o_TX_Serial);
    end
    bus8.i_TX_DV = 1'b1; bus8.i_TX_Byte = 8'h00;
    @(posedge clk); #1;
    n_checks++;
    if (bus8.o_TX_Active !== 1'b0 || ns8 !== s_IDLE) begin
      n_fail++;
      $display("FAIL reset_beats_dv: got act=%b ns=%0d, want 0 0", bus8.o_TX_Active, ns8);
    end
    bus8.i_TX_DV = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus8.o_TX_Serial !== 1'b1 || bus8.o_TX_Active !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got ser=%b act=%b, want 1 0", bus8.o_TX_Serial, bus8.o_TX_Active);
    end
  endtask

  task automatic test_single;
    logic [63:0] l, a, d, el, ea, ed;
    logic [7:0]  dec;
    send(1'b0, 8'hA5);
    record(1'b0, 48, l, a, d);
    el = exp_line(8'hA5, 8); ea = exp_act(8); ed = exp_done(8);
    for (int i = 0; i < 8; i++) dec[i] = l[CPB*(i+1)+2];
    n_checks++;
    if (l[47:0] !== el[47:0]) begin
      n_fail++; $display("FAIL a5_line: got %h want %h", l[47:0], el[47:0]);
    end
    n_checks++;
    if (dec !== 8'hA5) begin
      n_fail++; $display("FAIL a5_decoded: got %h want a5", dec);
    end
    n_checks++;
    if (a[47:0] !== ea[47:0]) begin
      n_fail++; $display("FAIL a5_active: got %h want %h", a[47:0], ea[47:0]);
    end
    n_checks++;
    if (d[47:0] !== ed[47:0]) begin
      n_fail++; $display("FAIL a5_done: got %h want %h", d[47:0], ed[47:0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] l1, a1, d1, l2, a2, d2, el, ed, ea;
    send(1'b0, 8'h00);
    record(1'b0, 41, l1, a1, d1);
    el = exp_line(8'h00, 8); ed = exp_done(8);
    n_checks++;
    if (l1[40:0] !== el[40:0] || d1[40:0] !== ed[40:0]) begin
      n_fail++; $display("FAIL b2b_first: got line %h done %h want %h %h", l1[40:0], d1[40:0], el[40:0], ed[40:0]);
    end
    n_checks++;
    if (bus8.o_TX_Serial !== 1'b1 || bus8.o_TX_Active !== 1'b0) begin
      n_fail++; $display("FAIL b2b_gap: got ser=%b act=%b want 1 0", bus8.o_TX_Serial, bus8.o_TX_Active);
    end
    send(1'b0, 8'hFF);
    record(1'b0, 48, l2, a2, d2);
    el = exp_line(8'hFF, 8); ea = exp_act(8);
    n_checks++;
    if (l2[47:0] !== el[47:0] || a2[47:0] !== ea[47:0] || d2[47:0] !== ed[47:0]) begin
      n_fail++; $display("FAIL b2b_second: got line %h act %h done %h want %h %h %h",
                         l2[47:0], a2[47:0], d2[47:0], el[47:0], ea[47:0], ed[47:0]);
    end
  endtask

  task automatic test_ignored_strobe;
    logic [63:0] l1, a1, d1, l2, a2, d2, l3, a3, d3, l, a, d, el, ea, ed;
    send(1'b0, 8'h81);
    record(1'b0, 10, l1, a1, d1);
    bus8.i_TX_DV = 1'b1; bus8.i_TX_Byte = 8'h3C;
    record(1'b0, 1, l2, a2, d2);
    bus8.i_TX_DV = 1'b0; bus8.i_TX_Byte = 8'h00;
    record(1'b0, 37, l3, a3, d3);
    l = l1 | (l2 << 10) | (l3 << 11);
    a = a1 | (a2 << 10) | (a3 << 11);
    d = d1 | (d2 << 10) | (d3 << 11);
    el = exp_line(8'h81, 8); ea = exp_act(8); ed = exp_done(8);
    n_checks++;
    if (l[47:0] !== el[47:0]) begin
      n_fail++; $display("FAIL ignore_line: got %h want %h", l[47:0], el[47:0]);
    end
    n_checks++;
    if (a[47:0] !== ea[47:0] || d[47:0] !== ed[47:0]) begin
      n_fail++; $display("FAIL ignore_flags: got act %h done %h want %h %h", a[47:0], d[47:0], ea[47:0], ed[47:0]);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [63:0] l, a, d, el, ea, ed;
    send(1'b0, 8'hF0);
    record(1'b0, 17, l, a, d);
    el = exp_line(8'hF0, 8);
    n_checks++;
    if (l[16:0] !== el[16:0] || bus8.o_TX_Serial !== 1'b0 || bus8.o_TX_Active !== 1'b1) begin
      n_fail++; $display("FAIL f0_before_reset: got line %h ser=%b act=%b want %h 0 1",
                         l[16:0], bus8.o_TX_Serial, bus8.o_TX_Active, el[16:0]);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus8.o_TX_Serial !== 1'b1 || bus8.o_TX_Active !== 1'b0 || ns8 !== s_IDLE) begin
      n_fail++; $display("FAIL mid_reset: got ser=%b act=%b ns=%0d want 1 0 0",
                         bus8.o_TX_Serial, bus8.o_TX_Active, ns8);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus8.o_TX_Serial !== 1'b1 || bus8.o_TX_Done !== 1'b0) begin
      n_fail++; $display("FAIL after_reset_idle: got ser=%b done=%b want 1 0", bus8.o_TX_Serial, bus8.o_TX_Done);
    end
    send(1'b0, 8'h55);
    record(1'b0, 48, l, a, d);
    el = exp_line(8'h55, 8); ea = exp_act(8); ed = exp_done(8);
    n_checks++;
    if (l[47:0] !== el[47:0] || a[47:0] !== ea[47:0] || d[47:0] !== ed[47:0]) begin
      n_fail++; $display("FAIL post_reset_55: got line %h act %h done %h want %h %h %h",
                         l[47:0], a[47:0], d[47:0], el[47:0], ea[47:0], ed[47:0]);
    end
  endtask

  task automatic test_continuous;
    logic [63:0] l, a, d, el, ea, ed;
    el = exp_line(8'h5A, 8); ea = exp_act(8); ed = exp_done(8);
    bus8.i_TX_DV = 1'b1; bus8.i_TX_Byte = 8'h5A;
    @(posedge clk); #1;
    for (int f = 0; f < 3; f++) begin
      if (f == 2) bus8.i_TX_DV = 1'b0;
      record(1'b0, 42, l, a, d);
      n_checks++;
      if (l[41:0] !== el[41:0] || a[41:0] !== ea[41:0] || d[41:0] !== ed[41:0]) begin
        n_fail++; $display("FAIL cont_frame%0d: got line %h act %h done %h want %h %h %h",
                           f, l[41:0], a[41:0], d[41:0], el[41:0], ea[41:0], ed[41:0]);
      end
    end
    n_checks++;
    if (bus8.o_TX_Active !== 1'b0) begin
      n_fail++; $display("FAIL cont_stop: got act=%b want 0", bus8.o_TX_Active);
    end
  endtask

  task automatic test_data_bits_5;
    logic [63:0] l, a, d, el, ea, ed;
    logic [4:0]  dec;
    send(1'b1, 8'h13);
    record(1'b1, 34, l, a, d);
    el = exp_line(8'h13, 5); ea = exp_act(5); ed = exp_done(5);
    for (int i = 0; i < 5; i++) dec[i] = l[CPB*(i+1)+2];
    n_checks++;
    if (l[33:0] !== el[33:0] || dec !== 5'h13) begin
      n_fail++; $display("FAIL db5_line: got %h (bits %h) want %h (bits 13)", l[33:0], dec, el[33:0]);
    end
    n_checks++;
    if (a[33:0] !== ea[33:0] || $countones(a) != 29) begin
      n_fail++; $display("FAIL db5_active: got %h want %h", a[33:0], ea[33:0]);
    end
    n_checks++;
    if (d[33:0] !== ed[33:0]) begin
      n_fail++; $display("FAIL db5_done: got %h want %h", d[33:0], ed[33:0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus8.i_TX_DV = 1'b0; bus8.i_TX_Byte = 8'h00;
    bus5.i_TX_DV = 1'b0; bus5.i_TX_Byte = 8'h00;
    test_reset;
    test_single;
    test_back_to_back;
    test_ignored_strobe;
    test_reset_mid_frame;
    test_continuous;
    test_data_bits_5;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
